// File: rtl/wdt_pkg.sv
// Shared types and constants for the watchdog interrupt bridge.
package wdt_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        SERVICED,
        ESCALATE
    } wdt_irq_state_e;

    localparam int unsigned ESC_CYCLES_DEF  = 1024;
    localparam int unsigned SYNC_STAGES_DEF = 2;
    localparam int unsigned WTO_CNT_W       = 8;

    function automatic logic [WTO_CNT_W-1:0] sat_inc(input logic [WTO_CNT_W-1:0] v);
        return (v == '1) ? v : v + WTO_CNT_W'(1);
    endfunction

endpackage

// File: rtl/bit_sync.sv
// N-flop single-bit synchroniser, async active-low reset, reset value 0.
module bit_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/wdt_irq_bridge.sv
// Synchronises the WDT timeout level, raises a CPU interrupt on its rising
// edge and escalates to a sticky reset request if software does not service it.
module wdt_irq_bridge
    import wdt_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int unsigned ESC_CYCLES  = ESC_CYCLES_DEF,
    parameter int unsigned ESC_W       = $clog2(ESC_CYCLES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wto_async,
    input  logic                 irq_en,
    input  logic                 irq_ack,
    output logic                 irq_o,
    output logic                 pending_o,
    output logic                 rst_req_o,
    output logic [WTO_CNT_W-1:0] wto_cnt_o
);

    localparam logic [ESC_W-1:0] ESC_LAST = ESC_W'(ESC_CYCLES - 1);

    wdt_irq_state_e       state_q, state_d;
    logic [ESC_W-1:0]     esc_cnt_q, esc_cnt_d;
    logic [WTO_CNT_W-1:0] wto_cnt_q;
    logic                 wto_sync;
    logic                 wto_d_q;
    logic                 sync_flushed;
    logic                 wto_rise;

    bit_sync #(
        .STAGES(SYNC_STAGES)
    ) u_wto_sync (
        .clk(clk),
        .rst(rst),
        .d_i(wto_async),
        .q_o(wto_sync)
    );

    // Goes high once the synchroniser holds real samples rather than reset
    // zeros; until then the edge flop reads as high so a level held through
    // reset cannot look like a fresh rising edge.
    bit_sync #(
        .STAGES(SYNC_STAGES)
    ) u_flush (
        .clk(clk),
        .rst(rst),
        .d_i(1'b1),
        .q_o(sync_flushed)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wto_d_q <= 1'b0;
        end else begin
            wto_d_q <= wto_sync | ~sync_flushed;
        end
    end

    assign wto_rise = wto_sync & ~wto_d_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wto_cnt_q <= '0;
        end else if (wto_rise) begin
            wto_cnt_q <= sat_inc(wto_cnt_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            esc_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            esc_cnt_q <= esc_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        esc_cnt_d = esc_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (wto_rise) begin
                    state_d   = PENDING;
                    esc_cnt_d = '0;
                end
            end
            PENDING: begin
                esc_cnt_d = esc_cnt_q + ESC_W'(1);
                if (irq_ack) begin
                    state_d   = SERVICED;
                    esc_cnt_d = '0;
                end else if (esc_cnt_q == ESC_LAST) begin
                    state_d = ESCALATE;
                end
            end
            SERVICED: begin
                esc_cnt_d = esc_cnt_q + ESC_W'(1);
                if (!wto_sync) begin
                    state_d = IDLE;
                end else if (esc_cnt_q == ESC_LAST) begin
                    state_d = ESCALATE;
                end
            end
            ESCALATE: begin
                state_d = ESCALATE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign irq_o     = (state_q == PENDING) & irq_en;
    assign pending_o = (state_q == PENDING) | (state_q == SERVICED);
    assign rst_req_o = (state_q == ESCALATE);
    assign wto_cnt_o = wto_cnt_q;

endmodule
